irq_pend_latch: RTL and testbench



---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_sync_edge.sv | 29 ++
 rtl/irq_pend_latch.sv | 101 ++++++++++
 tb/tb_irq_pend_latch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request-capture stage:
// index-width derivation and the offer FSM state encoding.
package irq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Index width for n request lines; a single line still needs one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line two-flop synchroniser followed by a delay flop.
// Produces a one-cycle rising-edge pulse for each request line.
module irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] req,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= req;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A request held high yields a single pulse; it must drop before it can fire again.
  assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_pend_latch.sv
// Request-capture stage: sticky pending bits from synchronised rising edges,
// software mask, and a registered highest-index offer with valid/ready handshake.
module irq_pend_latch
  import irq_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int IDX_W = idx_w(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  req,
  input  logic             mask_we,
  input  logic [IN_W-1:0]  mask_d,
  input  logic             irq_ready,
  input  logic             ovf_clr,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [IN_W-1:0]  pend_vec,
  output logic             ovf
);

  logic [IN_W-1:0]  rise;
  logic [IN_W-1:0]  pend;
  logic [IN_W-1:0]  mask;
  logic [IN_W-1:0]  elig;
  logic [IN_W-1:0]  clr_vec;
  logic [IN_W-1:0]  pend_nx;
  logic             accept;
  logic             ovf_set;
  logic             ovf_nx;
  state_t           state, state_nx;
  logic [IDX_W-1:0] idx_nx;
  logic [IDX_W-1:0] sel_idx;

  function automatic logic [IDX_W-1:0] hi_idx(input logic [IN_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  irq_sync_edge #(.W(IN_W)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .rise (rise)
  );

  // Masked lines keep accumulating; the mask only gates selection and status.
  assign elig      = pend & ~mask;
  assign pend_vec  = elig;
  assign irq_valid = (state == OFFER);
  assign accept    = irq_valid & irq_ready;
  assign sel_idx   = hi_idx(elig);

  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[irq_idx] = 1'b1;
  end

  // A fresh edge beats a same-cycle accept, so the line is re-armed, not lost.
  assign pend_nx = (pend & ~clr_vec) | rise;
  assign ovf_set = |(rise & pend & ~clr_vec);
  assign ovf_nx  = ovf_set | (ovf & ~ovf_clr);

  always_comb begin
    state_nx = state;
    idx_nx   = irq_idx;
    unique case (state)
      IDLE: begin
        if (|elig) begin
          idx_nx   = sel_idx;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        // Offered index is frozen until accepted; no preemption.
        if (irq_ready) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      mask    <= '0;
      ovf     <= 1'b0;
      state   <= IDLE;
      irq_idx <= '0;
    end else begin
      pend    <= pend_nx;
      ovf     <= ovf_nx;
      state   <= state_nx;
      irq_idx <= idx_nx;
      if (mask_we) mask <= mask_d;
    end
  end

endmodule

// File: tb/tb_irq_pend_latch.sv
// Self-checking bench for irq_pend_latch: reset, a vector table, directed
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_irq_pend_latch;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [IN_W-1:0]  req = '0;
  logic             mask_we = 1'b0;
  logic [IN_W-1:0]  mask_d = '0;
  logic             irq_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             irq_valid;
  logic [IDX_W-1:0] irq_idx;
  logic [IN_W-1:0]  pend_vec;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;

  irq_pend_latch #(.IN_W(IN_W), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask_we  (mask_we),
    .mask_d   (mask_d),
    .irq_ready(irq_ready),
    .ovf_clr  (ovf_clr),
    .irq_valid(irq_valid),
    .irq_idx  (irq_idx),
    .pend_vec (pend_vec),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic [7:0] exp_pv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] r, input logic rd, input logic v,
                     input logic [2:0] ix, input logic [7:0] pv);
    vec_t e;
    e.req = r; e.ready = rd; e.exp_valid = v; e.exp_idx = ix; e.exp_pv = pv;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int limit);
    int k;
    k = 0;
    while (irq_valid !== 1'b1 && k < limit) begin
      cyc();
      k++;
    end
    check(name, irq_valid, 1);
  endtask

  // Behavioural reference: request history, pending set, one offer slot.
  logic [7:0] h1, h2, h3, m_pend, m_mask;
  bit         m_valid, m_ovf;
  int         m_idx;

  task automatic model_reset();
    h1 = 0; h2 = 0; h3 = 0; m_pend = 0; m_mask = 0;
    m_valid = 0; m_ovf = 0; m_idx = 0;
  endtask

  task automatic model_step();
    logic [7:0] np;
    bit acc, set_ovf, rise, clr;
    int hi;
    acc = m_valid && irq_ready;
    set_ovf = 0;
    for (int i = 0; i < IN_W; i++) begin
      rise = h2[i] && !h3[i];
      clr  = acc && (m_idx == i);
      np[i] = rise || (m_pend[i] && !clr);
      if (rise && m_pend[i] && !clr) set_ovf = 1;
    end
    if (m_valid) begin
      if (irq_ready) m_valid = 0;
    end else begin
      hi = -1;
      for (int i = 0; i < IN_W; i++) if (m_pend[i] && !m_mask[i]) hi = i;
      if (hi >= 0) begin
        m_valid = 1;
        m_idx = hi;
      end
    end
    m_ovf = set_ovf || (m_ovf && !ovf_clr);
    m_pend = np;
    if (mask_we) m_mask = mask_d;
    h3 = h2; h2 = h1; h1 = req;
  endtask

  initial begin
    // Reset with random requests
    for (int i = 0; i < 4; i++) begin
      req = 8'($urandom);
      cyc();
      check("rst_valid", irq_valid, 0);
      check("rst_idx", irq_idx, 0);
      check("rst_pv", pend_vec, 0);
      check("rst_ovf", ovf, 0);
    end
    req = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_after_rst", irq_valid, 0);
    end

    // Vector table: line 5 held, long stall, accept; then line 0
    add(8'h20, 0, 0, 0, 8'h00);
    add(8'h20, 0, 0, 0, 8'h00);
    add(8'h20, 0, 0, 0, 8'h20);
    for (int i = 0; i < 10; i++) add(8'h20, 0, 1, 5, 8'h20);
    add(8'h20, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) add(8'h00, 0, 0, 0, 8'h00);
    add(8'h01, 0, 0, 0, 8'h00);
    add(8'h01, 0, 0, 0, 8'h00);
    add(8'h01, 0, 0, 0, 8'h01);
    add(8'h01, 0, 1, 0, 8'h01);
    add(8'h00, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) add(8'h00, 0, 0, 0, 8'h00);
    foreach (tbl[k]) begin
      req = tbl[k].req;
      irq_ready = tbl[k].ready;
      cyc();
      check($sformatf("tbl%0d_valid", k), irq_valid, tbl[k].exp_valid);
      check($sformatf("tbl%0d_pv", k), pend_vec, tbl[k].exp_pv);
      if (tbl[k].exp_valid) check($sformatf("tbl%0d_idx", k), irq_idx, tbl[k].exp_idx);
    end
    req = '0; irq_ready = 1'b0;

    // Priority without preemption
    req = 8'h04; cyc(); req = 8'h00;
    wait_valid("prio_wait2", 10);
    check("prio_idx2", irq_idx, 2);
    req = 8'h80; cyc(); req = 8'h00;
    repeat (5) cyc();
    check("prio_hold_valid", irq_valid, 1);
    check("prio_hold_idx", irq_idx, 2);
    check("prio_pv", pend_vec, 8'h84);
    irq_ready = 1'b1; cyc(); irq_ready = 1'b0;
    check("prio_gap", irq_valid, 0);
    cyc();
    check("prio_next_valid", irq_valid, 1);
    check("prio_next_idx", irq_idx, 7);
    irq_ready = 1'b1; cyc(); irq_ready = 1'b0;
    check("prio_done_pv", pend_vec, 0);

    // Mask excludes line 7 from selection and status
    mask_we = 1'b1; mask_d = 8'h80; cyc(); mask_we = 1'b0;
    req = 8'h88; cyc(); req = 8'h00;
    wait_valid("mask_wait", 10);
    check("mask_idx", irq_idx, 3);
    check("mask_pv", pend_vec, 8'h08);
    mask_we = 1'b1; mask_d = 8'h00; irq_ready = 1'b1; cyc();
    mask_we = 1'b0; irq_ready = 1'b0;
    check("mask_acc", irq_valid, 0);
    cyc();
    check("unmask_valid", irq_valid, 1);
    check("unmask_idx", irq_idx, 7);
    irq_ready = 1'b1; cyc(); irq_ready = 1'b0;

    // Overflow: second edge on a pending line
    req = 8'h10; cyc(); req = 8'h00; cyc(); cyc();
    req = 8'h10; cyc(); req = 8'h00;
    repeat (4) cyc();
    check("ovf_set", ovf, 1);
    check("ovf_valid", irq_valid, 1);
    check("ovf_idx", irq_idx, 4);
    irq_ready = 1'b1; cyc(); irq_ready = 1'b0;
    repeat (4) cyc();
    check("ovf_one_offer", irq_valid, 0);
    check("ovf_pv", pend_vec, 0);
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);

    // Edge landing on the accept cycle re-arms without overflow
    req = 8'h10; cyc(); req = 8'h00;
    wait_valid("coll_wait", 10);
    req = 8'h10; cyc();
    req = 8'h00; cyc();
    irq_ready = 1'b1; cyc(); irq_ready = 1'b0;
    check("coll_valid", irq_valid, 0);
    check("coll_pv", pend_vec, 8'h10);
    check("coll_ovf", ovf, 0);
    cyc();
    check("coll_reoffer", irq_valid, 1);
    check("coll_idx", irq_idx, 4);
    irq_ready = 1'b1; cyc(); irq_ready = 1'b0;

    // Randomized traffic against the reference model
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i == 1200) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rnd_rst_valid", irq_valid, 0);
        check("rnd_rst_pv", pend_vec, 0);
        cyc();
        rst_n = 1'b1;
      end
      for (int b = 0; b < IN_W; b++) if ($urandom_range(3) == 0) req[b] = ~req[b];
      irq_ready = ($urandom_range(1) == 1);
      mask_we   = ($urandom_range(19) == 0);
      mask_d    = 8'($urandom);
      ovf_clr   = ($urandom_range(19) == 0);
      model_step();
      cyc();
      check("rnd_valid", irq_valid, m_valid);
      check("rnd_pv", pend_vec, m_pend & ~m_mask);
      check("rnd_ovf", ovf, m_ovf);
      if (m_valid) check("rnd_idx", irq_idx, m_idx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
